// File: rtl/cnt_pwm_gen.sv
// cnt_pwm_gen: PWM generator driven by an external up counter, with shadowed duty updates applied at period boundaries.
// Define CNT_PWM_COMPL_EN to add the complementary dead-time output pwm_n.
module cnt_pwm_gen #(
    parameter int CNT_W  = 4,
    parameter int PCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CNT_W-1:0]  cnt,
    input  logic [CNT_W:0]    duty_in,
    input  logic              duty_valid,
    output logic              duty_ready,
    output logic              pwm_out,
    output logic              period_pulse,
`ifdef CNT_PWM_COMPL_EN
    output logic              pwm_n,
`endif
    output logic [PCNT_W-1:0] period_cnt
);
    localparam logic [CNT_W:0] DUTY_MAX = {1'b1, {CNT_W{1'b0}}};
    logic [CNT_W:0]   active_duty, shadow, eff, sat;
    logic [CNT_W-1:0] prev_cnt;
    logic             pend, started, bnd, acc, pwm_nxt;
    // a held-at-zero count only marks the first cycle; the first zero after reset always counts
    assign bnd        = (cnt == '0) && (prev_cnt != '0 || !started);
    assign duty_ready = !pend;
    assign acc        = duty_valid && !pend;
    assign sat        = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;
    assign eff        = (bnd && pend) ? shadow : active_duty;
    assign pwm_nxt    = {1'b0, cnt} < eff;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_duty  <= '0;
            shadow       <= '0;
            pend         <= 1'b0;
            prev_cnt     <= '0;
            started      <= 1'b0;
            pwm_out      <= 1'b0;
            period_pulse <= 1'b0;
            period_cnt   <= '0;
        end else begin
            prev_cnt     <= cnt;
            started      <= 1'b1;
            pwm_out      <= pwm_nxt;
            period_pulse <= bnd;
            if (bnd)
                period_cnt <= period_cnt + PCNT_W'(1);
            // a value accepted on a boundary cycle waits for the following boundary
            if (bnd && pend) begin
                active_duty <= shadow;
                pend        <= 1'b0;
            end else if (acc) begin
                shadow <= sat;
                pend   <= 1'b1;
            end
        end
    end
`ifdef CNT_PWM_COMPL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pwm_n <= 1'b0;
        else
            pwm_n <= (pwm_nxt != pwm_out) ? 1'b0 : !pwm_nxt;
    end
`endif
endmodule

// File: tb/tb_cnt_pwm_gen.sv
// tb_cnt_pwm_gen: scoreboard bench for cnt_pwm_gen against a queue-based reference model.
module tb_cnt_pwm_gen;
    localparam int CNT_W  = 4;
    localparam int PCNT_W = 8;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [CNT_W-1:0]  cnt = '0;
    logic [CNT_W:0]    duty_in = '0;
    logic              duty_valid = 1'b0;
    logic              duty_ready, pwm_out, period_pulse;
    logic [PCNT_W-1:0] period_cnt;
`ifdef CNT_PWM_COMPL_EN
    logic              pwm_n;
`endif
    cnt_pwm_gen #(.CNT_W(CNT_W), .PCNT_W(PCNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .cnt(cnt), .duty_in(duty_in), .duty_valid(duty_valid),
        .duty_ready(duty_ready), .pwm_out(pwm_out), .period_pulse(period_pulse),
`ifdef CNT_PWM_COMPL_EN
        .pwm_n(pwm_n),
`endif
        .period_cnt(period_cnt)
    );
    always #5 clk = !clk;

    typedef struct {
        bit pwm;
        bit pulse;
        int pcnt;
        bit ready;
        bit pwmn;
    } exp_t;
    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // reference model: requested duties wait in a queue until a period starts
    int pending[$];
    int duty, last_cnt, periods, cur;
    bit seen_edge, last_pwm;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        pending.delete();
        duty = 0; last_cnt = 0; periods = 0; seen_edge = 0; last_pwm = 0;
    endtask

    // drive one cycle of stimulus at a negedge, predict the post-edge outputs, then wait for the next negedge
    task automatic step(input int c, input bit v, input int d);
        exp_t e;
        bit new_period, was_ready;
        cnt = CNT_W'(c); duty_valid = v; duty_in = (CNT_W+1)'(d); cur = c;
        new_period = (c == 0) && (!seen_edge || last_cnt != 0);
        was_ready = (pending.size() == 0);
        if (new_period && !was_ready) duty = pending.pop_front();
        if (v && was_ready) pending.push_back(d > 16 ? 16 : d);
        if (new_period) periods = (periods + 1) % 256;
        e.pwm = (c < duty);
        e.pulse = new_period;
        e.pcnt = periods;
        e.ready = (pending.size() == 0);
        e.pwmn = (e.pwm != last_pwm) ? 1'b0 : !e.pwm;
        last_pwm = e.pwm; last_cnt = c; seen_edge = 1;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic advance(input int n);
        repeat (n) step((cur + 1) % 16, 0, 0);
    endtask

    task automatic goto_cnt(input int t);
        while ((cur + 1) % 16 != t) advance(1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pwm"}, pwm_out, 0);
        check({tag, "_pulse"}, period_pulse, 0);
        check({tag, "_pcnt"}, period_cnt, 0);
        check({tag, "_ready"}, duty_ready, 1);
`ifdef CNT_PWM_COMPL_EN
        check({tag, "_pwmn"}, pwm_n, 0);
`endif
    endtask

    // monitor: one expected entry per clock edge taken while out of reset
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pwm_out", pwm_out, e.pwm);
            check("period_pulse", period_pulse, e.pulse);
            check("period_cnt", period_cnt, e.pcnt);
            check("duty_ready", duty_ready, e.ready);
`ifdef CNT_PWM_COMPL_EN
            check("pwm_n", pwm_n, e.pwmn);
            check("no_overlap", pwm_out & pwm_n, 0);
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        #12;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0);
        advance(47);
        goto_cnt(7);
        step(7, 1, 5);
        advance(40);
        step((cur + 1) % 16, 1, 16);
        advance(24);
        step((cur + 1) % 16, 1, 0);
        advance(24);
        step((cur + 1) % 16, 1, 20);
        advance(24);
        step((cur + 1) % 16, 1, 8);
        advance(40);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 1, 6);
        advance(20);
        goto_cnt(5);
        step(5, 1, 3);
        goto_cnt(9);
        step(0, 0, 0);
        advance(20);
        goto_cnt(2);
        step(2, 1, 11);
        goto_cnt(10);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        repeat (3) @(negedge clk);
        check_reset_outputs("held_rst");
        model_reset();
        rst_n = 1'b1;
        step(11, 0, 0);
        advance(36);
        for (int i = 0; i < 3000; i++) begin
            int r, nc;
            r = $urandom_range(0, 99);
            nc = (r < 4) ? 0 : (r < 8) ? cur : (cur + 1) % 16;
            step(nc, $urandom_range(0, 4) == 0, $urandom_range(0, 20));
        end
        @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cnt_pwm_gen.md
Name: cnt_pwm_gen

Overview:
- Downstream consumer of the free-running 4-bit up counter: takes its `cnt` value and produces a glitch-free PWM waveform, a period strobe and a period tally.
- Duty-cycle updates arrive over a valid/ready handshake. They are held in a shadow register and applied only at a period boundary, so a pulse is never truncated mid-period.
- Shares `clk` and `rst_n` with the counter.

Parameters:
- CNT_W, 4, width of the incoming count; the period is 2**CNT_W cycles.
- PCNT_W, 8, width of the period tally counter.

Ports:
- clk  input  1  system clock; rising edge active.
- rst_n  input  1  asynchronous active-low reset.
- cnt  input  CNT_W  count from the upstream up counter, sampled every rising edge.
- duty_in  input  CNT_W+1  requested high-time in cycles, range 0..2**CNT_W.
- duty_valid  input  1  duty_in is valid.
- duty_ready  output  1  block can accept a new duty value.
- pwm_out  output  1  registered PWM output.
- period_pulse  output  1  one-cycle strobe, registered, marks a period boundary.
- period_cnt  output  PCNT_W  number of boundaries seen since reset; wraps.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Outputs: pwm_out=0, period_pulse=0, period_cnt=0, duty_ready=1.
  - Internal state: active_duty=0, shadow=0, pend=0, prev_cnt=0, started=0.
- Boundary condition, evaluated each cycle: `bnd` = (cnt==0) AND (prev_cnt!=0 OR started==0).
  - This covers the 15->0 wrap, an upstream clear mid-period, and the first cycle after reset.
  - Every edge: prev_cnt <= cnt and started <= 1.
  - Consecutive cycles with cnt==0 after the first produce no further boundary.
- Handshake:
  - duty_ready = !pend.
  - Accept when duty_valid && duty_ready: shadow <= min(duty_in, 2**CNT_W), i.e. saturate at 16; then pend <= 1.
  - duty_in is ignored while duty_ready=0.
- Duty application:
  - eff = (bnd && pend) ? shadow : active_duty.
  - On bnd with pend=1: active_duty <= shadow and pend <= 0, so duty_ready returns high the next cycle.
  - Accept and bnd in the same cycle (only possible with pend=0): the newly accepted value waits for the next boundary.
- PWM output:
  - pwm_out <= (cnt < eff), one-cycle latency from cnt.
  - duty 0 gives pwm_out constantly 0; duty 16 gives constantly 1; duty 5 gives high for cnt 0..4.
- Period tracking:
  - period_pulse <= bnd.
  - On bnd, period_cnt <= period_cnt+1, wrapping from 2**PCNT_W-1 to 0.
- Upstream clear mid-period (cnt drops to 0 with rst_n high): treated as a full boundary. Pending duty is applied, period_pulse fires, period_cnt increments.
- rst_n asserted mid-operation: all state is cleared immediately, any pending duty is lost, and duty_ready=1 again.

Optional Feature:
- Macro: CNT_PWM_COMPL_EN.
- When defined: adds output `pwm_n` (1 bit, reset 0), a complementary output with one-cycle dead time.
  - pwm_n is registered as the inverse of pwm_out's next value, but is forced low in any cycle where pwm_out changes value.
  - pwm_out and pwm_n are never both 1.
- When undefined: no pwm_n port and no extra logic; all other behaviour is identical.

Test Plan:
- Reset then free-running cnt 0..15, no duty written -> pwm_out=0 throughout; period_pulse one cycle after each cnt==0; period_cnt = 1, 2, 3...
- Write duty 5 while cnt=7 -> duty_ready falls the next cycle; pwm_out stays 0 until cnt wraps to 0, then is high for exactly 5 cycles per period; duty_ready returns to 1 after the boundary.
- Write duty 16, later duty 0 -> pwm_out constantly 1 for a full period, then constantly 0 from the next boundary. Write duty_in=20 -> behaves as 16.
- Upstream clear to 0 at cnt=9 with duty 3 pending -> boundary detected, period_cnt increments, pwm_out high for cnt 0..2 immediately.
- Assert rst_n at cnt=10 with pend=1 -> all outputs 0 asynchronously, duty_ready=1; after release, the first cnt==0 counts as a boundary and pwm_out stays 0.
- With CNT_PWM_COMPL_EN and duty 8 -> pwm_n low one cycle at each pwm_out edge, otherwise the inverse of pwm_out; never both high.
